// File: rtl/ita_requant_act_pkg.sv
// ita_package: shared ITA types for the requantization/activation stage.
// Provides the beat, step, activation and control types plus the step-to-constant index helper.
package ita_package;
    localparam int unsigned N                = 16;
    localparam int unsigned WO               = 26;
    localparam int unsigned WI               = 8;
    localparam int unsigned EMS              = 8;
    localparam int unsigned NumSteps         = 6;
    localparam int unsigned GeluConstWidth   = 16;
    localparam int unsigned GeluOutWidth     = 26;
    localparam int unsigned RequantProdWidth = WO + EMS + 1;

    typedef enum logic [2:0] {Q = 3'd0, K, V, QK, AV, OW, Idle} step_e;
    typedef enum logic [1:0] {IDENTITY = 2'd0, GELU = 2'd1, RELU = 2'd2} activation_e;

    typedef logic [EMS-1:0]                      requant_const_t;
    typedef requant_const_t [NumSteps-1:0]       requant_const_array_t;
    typedef logic signed [GeluConstWidth-1:0]    gelu_const_t;
    typedef logic signed [GeluOutWidth-1:0]      gelu_out_t;
    typedef logic [N-1:0][WO-1:0]                oup_t;
    typedef logic [N-1:0][WI-1:0]                requant_oup_t;

    typedef struct packed {
        requant_const_array_t eps_mult;
        requant_const_array_t right_shift;
        requant_const_array_t add;
        activation_e          activation;
        gelu_const_t          gelu_b;
        gelu_const_t          gelu_c;
        gelu_const_t          gelu_one;
        requant_const_t       gelu_requant_mult;
        requant_const_t       gelu_requant_shift;
        requant_const_t       gelu_requant_add;
    } ctrl_t;

    // Idle (and unused codes) are illegal on input; map them to slot 0 so the index stays in range
    function automatic logic [2:0] step_idx(step_e s);
        return (s > OW) ? 3'd0 : 3'(s);
    endfunction
endpackage

// File: rtl/ita_requant_act_requantizer.sv
// ita_requantizer: one lane of x*mult, round-half-up, arithmetic right shift, signed add, WI saturation.
// The multiply and the round/shift/add halves have separate ports so they can sit in different stages.
module ita_requantizer
    import ita_package::*;
#(
    parameter int unsigned InW = WO
) (
    input  logic signed [InW-1:0]   x_i,
    input  requant_const_t          mult_i,
    output logic signed [InW+EMS:0] prod_o,
    input  logic signed [InW+EMS:0] prod_i,
    input  requant_const_t          shift_i,
    input  requant_const_t          add_i,
    output logic signed [WI-1:0]    q_o
);
    localparam int unsigned PW = InW + EMS + 1;
    localparam logic signed [PW:0] ONE  = (PW+1)'(1);
    localparam logic signed [PW:0] QMAX = (PW+1)'(2 ** (WI - 1) - 1);
    localparam logic signed [PW:0] QMIN = ~QMAX;

    logic signed [PW-1:0] w_xe, w_me;
    logic signed [PW:0]   w_rnd, w_p, w_r, w_s;

    assign w_xe   = PW'(x_i);
    assign w_me   = PW'($signed({1'b0, mult_i}));
    assign prod_o = w_xe * w_me;

    assign w_rnd = (shift_i != '0) ? (ONE << (shift_i - EMS'(1))) : '0;
    assign w_p   = (PW+1)'(prod_i) + w_rnd;
    assign w_r   = w_p >>> shift_i;
    assign w_s   = w_r + (PW+1)'($signed(add_i));
    assign q_o   = (w_s > QMAX) ? WI'(QMAX) : (w_s < QMIN) ? WI'(QMIN) : w_s[WI-1:0];
endmodule

// File: rtl/ita_requant_act.sv
// ita_requant_act: 3-stage requantization and activation (identity / ReLU / i-GELU) of ITA accumulator beats.
// Define ITA_GELU_EN to build the S3 GELU polynomial and its requantizer; otherwise GELU acts as identity.
module ita_requant_act
    import ita_package::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  ctrl_t        ctrl_i,
    input  logic         inp_valid_i,
    output logic         inp_ready_o,
    input  oup_t         inp_i,
    input  step_e        inp_step_i,
    output logic         oup_valid_o,
    input  logic         oup_ready_i,
    output requant_oup_t oup_o,
    output logic         busy_o
);
    localparam int unsigned PW = RequantProdWidth;

    logic                 r_v1, r_v2, r_v3;
    step_e                r_step1, r_step2, r_step3;
    logic [N-1:0][PW-1:0] r_prod1, w_prod;
    requant_oup_t         r_q2, r_q3, w_s2, w_s3;
    logic                 w_en1, w_en2, w_en3, w_relu1;
    logic [2:0]           w_idx0, w_idx1;

    // enables ripple back from the output so a full pipeline accepts in the same cycle it drains
    assign w_en3       = !r_v3 || oup_ready_i;
    assign w_en2       = !r_v2 || w_en3;
    assign w_en1       = !r_v1 || w_en2;
    assign inp_ready_o = w_en1;
    assign oup_valid_o = r_v3;
    assign oup_o       = r_q3;
    assign busy_o      = r_v1 || r_v2 || r_v3;

    assign w_idx0  = step_idx(inp_step_i);
    assign w_idx1  = step_idx(r_step1);
    assign w_relu1 = (r_step1 == OW) && (ctrl_i.activation == RELU);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [WI-1:0] w_q;
        ita_requantizer #(.InW(WO)) u_rq (
            .x_i    (inp_i[i]),
            .mult_i (ctrl_i.eps_mult[w_idx0]),
            .prod_o (w_prod[i]),
            .prod_i (r_prod1[i]),
            .shift_i(ctrl_i.right_shift[w_idx1]),
            .add_i  (ctrl_i.add[w_idx1]),
            .q_o    (w_q)
        );
        assign w_s2[i] = (w_relu1 && w_q[WI-1]) ? '0 : w_q;
    end

`ifdef ITA_GELU_EN
    localparam int unsigned GW = 48;
    localparam logic signed [GW-1:0] GMAX = GW'(2 ** (GeluOutWidth - 1) - 1);
    localparam logic signed [GW-1:0] GMIN = ~GMAX;
    logic w_gelu2;
    assign w_gelu2 = (r_step2 == OW) && (ctrl_i.activation == GELU);
    for (genvar i = 0; i < N; i++) begin : g_gelu
        logic signed [GW-1:0]  w_q, w_b, w_abs, w_a, w_t, w_p, w_l, w_g;
        gelu_out_t             w_gs;
        logic [PW-1:0]         w_gp;
        logic signed [WI-1:0]  w_gq;
        assign w_q   = GW'($signed(r_q2[i]));
        assign w_b   = GW'($signed(ctrl_i.gelu_b));
        assign w_abs = w_q[GW-1] ? -w_q : w_q;
        assign w_a   = (w_abs < -w_b) ? w_abs : -w_b;
        assign w_t   = w_a + w_b;
        assign w_p   = w_t * w_t + GW'($signed(ctrl_i.gelu_c));
        assign w_l   = w_q[GW-1] ? -w_p : w_p;
        assign w_g   = w_q * (w_l + GW'($signed(ctrl_i.gelu_one)));
        assign w_gs  = (w_g > GMAX) ? GeluOutWidth'(GMAX) : (w_g < GMIN) ? GeluOutWidth'(GMIN) : w_g[GeluOutWidth-1:0];
        ita_requantizer #(.InW(GeluOutWidth)) u_grq (
            .x_i    (w_gs),
            .mult_i (ctrl_i.gelu_requant_mult),
            .prod_o (w_gp),
            .prod_i (w_gp),
            .shift_i(ctrl_i.gelu_requant_shift),
            .add_i  (ctrl_i.gelu_requant_add),
            .q_o    (w_gq)
        );
        assign w_s3[i] = w_gelu2 ? w_gq : r_q2[i];
    end
`else
    logic w_unused_gelu;
    assign w_s3 = r_q2;
    assign w_unused_gelu = ^{r_step2, ctrl_i.gelu_b, ctrl_i.gelu_c, ctrl_i.gelu_one,
                             ctrl_i.gelu_requant_mult, ctrl_i.gelu_requant_shift, ctrl_i.gelu_requant_add};
`endif

    logic w_unused_tag;
    assign w_unused_tag = ^r_step3;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_step1 <= Q;
            r_step2 <= Q;
            r_step3 <= Q;
            r_prod1 <= '0;
            r_q2    <= '0;
            r_q3    <= '0;
        end else begin
            if (w_en1) r_v1 <= inp_valid_i;
            if (w_en1 && inp_valid_i) begin
                r_step1 <= inp_step_i;
                r_prod1 <= w_prod;
            end
            if (w_en2) r_v2 <= r_v1;
            if (w_en2 && r_v1) begin
                r_step2 <= r_step1;
                r_q2    <= w_s2;
            end
            if (w_en3) r_v3 <= r_v2;
            if (w_en3 && r_v2) begin
                r_step3 <= r_step2;
                r_q3    <= w_s3;
            end
        end
    end
endmodule

// File: tb/tb_ita_requant_act.sv
// tb_ita_requant_act: directed table, stall/reset sequences and random handshake scoreboard for ita_requant_act.
module tb_ita_requant_act;
    import ita_package::*;

    localparam int NV = 12;
    localparam int EPS [6] = '{128, 128, 64, 3, 255, 128};
    localparam int SH  [6] = '{8, 8, 4, 0, 10, 8};
    localparam int ADD [6] = '{3, 3, -2, 0, 127, 3};
    localparam int GB = -22, GC = -121, GONE = 1000, GRM = 1, GRS = 10, GRA = 5;

    typedef struct {
        step_e       st;
        activation_e act;
        int          xa;
        int          xb;
        int          ea;
        int          eb;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_ni;
    ctrl_t        ctrl;
    logic         inp_valid, inp_ready, oup_valid, oup_ready, busy;
    oup_t         inp;
    step_e        step;
    requant_oup_t oup;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    ita_requant_act dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ctrl_i     (ctrl),
        .inp_valid_i(inp_valid),
        .inp_ready_o(inp_ready),
        .inp_i      (inp),
        .inp_step_i (step),
        .oup_valid_o(oup_valid),
        .oup_ready_i(oup_ready),
        .oup_o      (oup),
        .busy_o     (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input requant_oup_t act, input requant_oup_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rq(longint x, int m, int sh, int ad);
        longint p = x * longint'(m);
        if (sh > 0) p += longint'(1) << (sh - 1);
        p = (p >>> sh) + longint'(ad);
        return (p > 127) ? 127 : (p < -128) ? -128 : int'(p);
    endfunction

    function automatic int gelu_ref(int q);
        longint s = (q < 0) ? -1 : 1;
        longint a = (q < 0) ? -q : q;
        longint l, g;
        if (a > -GB) a = -GB;
        l = s * ((a + GB) * (a + GB) + GC);
        g = longint'(q) * (l + GONE);
        if (g > 33554431) g = 33554431;
        if (g < -33554432) g = -33554432;
        return rq(g, GRM, GRS, GRA);
    endfunction

    function automatic int lane_exp(longint x, int st, activation_e act);
        int q = rq(x, EPS[st], SH[st], ADD[st]);
        if (st == 5 && act == RELU && q < 0) q = 0;
`ifdef ITA_GELU_EN
        if (st == 5 && act == GELU) q = gelu_ref(q);
`endif
        return q;
    endfunction

    function automatic requant_oup_t pack_exp(oup_t x, step_e st, activation_e act);
        requant_oup_t r;
        for (int i = 0; i < int'(N); i++) r[i] = WI'(lane_exp(longint'($signed(x[i])), int'(st), act));
        return r;
    endfunction

    task automatic run_rand(input int nb, input int vpct, input int rpct, input activation_e act, output int cycles);
        oup_t         bi[$];
        step_e        bs[$];
        requant_oup_t be[$];
        int           sent = 0;
        int           rcv = 0;
        logic         held = 1'b0;
        ctrl.activation = act;
        for (int k = 0; k < nb; k++) begin
            oup_t  x;
            step_e s = step_e'($urandom_range(0, 5));
            for (int i = 0; i < int'(N); i++) begin
                longint v = ($urandom_range(0, 7) == 0) ? longint'($signed(26'($urandom)))
                                                        : longint'($urandom_range(0, 1200)) - 600;
                x[i] = 26'(v);
            end
            bi.push_back(x);
            bs.push_back(s);
            be.push_back(pack_exp(x, s, act));
        end
        cycles = 0;
        while (rcv < nb && cycles < 20 * nb + 50) begin
            inp_valid = (sent < nb) && ($urandom_range(1, 100) <= vpct);
            if (sent < nb) begin
                inp  = bi[sent];
                step = bs[sent];
            end
            oup_ready = ($urandom_range(1, 100) <= rpct);
            @(negedge clk);
            if (held) check("hold_valid", oup_valid, 1);
            if (oup_valid) begin
                if (rcv < nb) check_vec("order", oup, be[rcv]);
                else check("extra_beat", oup_valid, 0);
            end
            held = oup_valid && !oup_ready;
            if (oup_valid && oup_ready) rcv++;
            if (inp_valid && inp_ready) sent++;
            @(posedge clk);
            #1;
            cycles++;
        end
        inp_valid = 1'b0;
        check("beats_out", rcv, nb);
        check("drained_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[NV];
        requant_oup_t e;
        oup_t         sin[4];
        requant_oup_t sexp[4];
        int           n, sent, rcv, last_c, cyc, cnt;

        vt[0]  = '{Q,  IDENTITY, 100,    -100,    53,  -47};
        vt[1]  = '{Q,  IDENTITY, 100000, -100000, 127, -128};
        vt[2]  = '{OW, RELU,     -100,   100,     0,   53};
        vt[3]  = '{K,  RELU,     100,    -100,    53,  -47};
        vt[4]  = '{OW, IDENTITY, -100,   100,     -47, 53};
        vt[5]  = '{V,  RELU,     10,     -10,     38,  -42};
        vt[6]  = '{QK, IDENTITY, 20,     -50,     60,  -128};
        vt[7]  = '{AV, IDENTITY, 4,      -8,      127, 125};
        vt[8]  = '{OW, RELU,     0,      1,       3,   4};
`ifdef ITA_GELU_EN
        vt[9]  = '{OW, GELU,     -6,     -100,    5,   -46};
        vt[10] = '{OW, GELU,     100,    100000,  50,  114};
        vt[11] = '{OW, GELU,     14,     -26,     15,  -5};
`else
        vt[9]  = '{OW, GELU,     -6,     -100,    0,   -47};
        vt[10] = '{OW, GELU,     100,    100000,  53,  127};
        vt[11] = '{OW, GELU,     14,     -26,     10,  -10};
`endif

        rst_ni    = 1'b0;
        inp_valid = 1'b0;
        oup_ready = 1'b0;
        inp       = '0;
        step      = Q;
        ctrl      = '0;
        for (int i = 0; i < 6; i++) begin
            ctrl.eps_mult[i]    = 8'(EPS[i]);
            ctrl.right_shift[i] = 8'(SH[i]);
            ctrl.add[i]         = 8'(ADD[i]);
        end
        ctrl.gelu_b             = 16'(GB);
        ctrl.gelu_c             = 16'(GC);
        ctrl.gelu_one           = 16'(GONE);
        ctrl.gelu_requant_mult  = 8'(GRM);
        ctrl.gelu_requant_shift = 8'(GRS);
        ctrl.gelu_requant_add   = 8'(GRA);

        #12;
        check("rst_valid", oup_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", inp_ready, 1);
        check_vec("rst_data", oup, '0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            ctrl.activation = vt[v].act;
            step = vt[v].st;
            for (int i = 0; i < int'(N); i++) begin
                inp[i] = 26'((i % 2 == 1) ? vt[v].xb : vt[v].xa);
                e[i]   = 8'((i % 2 == 1) ? vt[v].eb : vt[v].ea);
            end
            inp_valid = 1'b1;
            oup_ready = 1'b1;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                inp_valid = 1'b0;
                n++;
            end while (!oup_valid && n < 10);
            check($sformatf("latency_v%0d", v), n, 3);
            check_vec($sformatf("data_v%0d", v), oup, e);
            @(posedge clk);
            #1;
        end

        ctrl.activation = IDENTITY;
        step = Q;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < int'(N); i++) sin[k][i] = 26'(10 * (k + 1) + i);
            sexp[k] = pack_exp(sin[k], Q, IDENTITY);
        end
        sent = 0;
        rcv = 0;
        last_c = -1;
        for (int c = 0; c < 12; c++) begin
            oup_ready = (c >= 5);
            inp_valid = (sent < 4);
            inp = sin[(sent < 4) ? sent : 3];
            @(negedge clk);
            if (c == 3) begin
                check("stall_accepted", sent, 3);
                check("stall_ready_c3", inp_ready, 0);
            end
            if (c == 4) check("stall_ready_c4", inp_ready, 0);
            if (oup_valid) begin
                if (rcv < 4) check_vec($sformatf("stall_data_c%0d", c), oup, sexp[rcv]);
                else check("stall_extra", oup_valid, 0);
                if (oup_ready) begin
                    rcv++;
                    last_c = c;
                end
            end
            if (inp_valid && inp_ready) sent++;
            @(posedge clk);
            #1;
        end
        inp_valid = 1'b0;
        check("stall_out", rcv, 4);
        check("stall_no_bubble", last_c, 8);

        oup_ready = 1'b0;
        inp_valid = 1'b1;
        for (int i = 0; i < int'(N); i++) inp[i] = 26'(100);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) inp[i] = 26'(-100);
        @(posedge clk);
        #1;
        inp_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_pre_valid", oup_valid, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_valid", oup_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", inp_ready, 1);
        check_vec("rst_mid_data", oup, '0);
        @(negedge clk);
        rst_ni = 1'b1;
        oup_ready = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (oup_valid) cnt++;
        end
        check("rst_no_stale", cnt, 0);

        run_rand(20, 100, 100, IDENTITY, cyc);
        check("throughput_cycles", cyc, 23);
        run_rand(500, 70, 60, RELU, cyc);
        run_rand(500, 60, 70, GELU, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
